// File: rtl/resizer_pkg.sv
// Shared resizer types: fixed-point widths, walker FSM states, coefficient beat layout.
// Latency: n/a (declarations and one combinational helper).
// Backpressure: n/a.
package resizer_pkg;

    localparam int CW     = 11;
    localparam int FRAC_W = 14;
    localparam int ACC_W  = CW + FRAC_W;
    localparam int W_W    = 16;

    localparam logic [W_W-1:0] ONE_Q14 = 16'd16384;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    typedef struct packed {
        logic [CW-1:0]     i0;
        logic [CW-1:0]     i1;
        logic [FRAC_W-1:0] f;
    } axis_t;

    typedef struct packed {
        logic [CW-1:0]  x0;
        logic [CW-1:0]  y0;
        logic [CW-1:0]  x1;
        logic [CW-1:0]  y1;
        logic [W_W-1:0] w00;
        logic [W_W-1:0] w01;
        logic [W_W-1:0] w10;
        logic [W_W-1:0] w11;
        logic           last_pix;
        logic           last_line;
    } beat_t;

    // Past the last source sample both taps collapse onto the edge and the fraction is dropped.
    function automatic axis_t clamp_axis(input logic [ACC_W-1:0] acc, input logic [CW-1:0] n);
        axis_t       a;
        logic [CW-1:0] i;
        logic [CW-1:0] nm1;
        i   = acc[ACC_W-1:FRAC_W];
        nm1 = n - 1'b1;
        if (i >= nm1) begin
            a.i0 = nm1;
            a.i1 = nm1;
            a.f  = '0;
        end else begin
            a.i0 = i;
            a.i1 = i + 1'b1;
            a.f  = acc[FRAC_W-1:0];
        end
        return a;
    endfunction

endpackage

// File: rtl/bilinear_coef_gen_if.sv
// Frame control and coefficient-beat bundle between the walker and the fetch/MAC side.
// Latency: n/a (wiring only).
// Backpressure: out_valid/out_ready handshake on the beat fields.
interface bilinear_coef_gen_if;

    logic                              start;
    logic [resizer_pkg::CW-1:0]        src_w;
    logic [resizer_pkg::CW-1:0]        src_h;
    logic [resizer_pkg::CW-1:0]        dst_w;
    logic [resizer_pkg::CW-1:0]        dst_h;
    logic [resizer_pkg::ACC_W-1:0]     step_x;
    logic [resizer_pkg::ACC_W-1:0]     step_y;
    logic                              busy;
    logic                              done;
    logic                              out_valid;
    logic                              out_ready;
    logic [resizer_pkg::CW-1:0]        x0;
    logic [resizer_pkg::CW-1:0]        y0;
    logic [resizer_pkg::CW-1:0]        x1;
    logic [resizer_pkg::CW-1:0]        y1;
    logic [resizer_pkg::W_W-1:0]       W00;
    logic [resizer_pkg::W_W-1:0]       W01;
    logic [resizer_pkg::W_W-1:0]       W10;
    logic [resizer_pkg::W_W-1:0]       W11;
    logic                              last_pix;
    logic                              last_line;

    modport master (
        input  start, src_w, src_h, dst_w, dst_h, step_x, step_y, out_ready,
        output busy, done, out_valid, x0, y0, x1, y1, W00, W01, W10, W11, last_pix, last_line
    );

    modport slave (
        output start, src_w, src_h, dst_w, dst_h, step_x, step_y, out_ready,
        input  busy, done, out_valid, x0, y0, x1, y1, W00, W01, W10, W11, last_pix, last_line
    );

endinterface

// File: rtl/bilinear_weight_calc.sv
// Bilinear Q2.14 weights from the clamped x/y fractions; the four always sum to ONE_Q14.
// Latency: combinational.
// Backpressure: none.
module bilinear_weight_calc
    import resizer_pkg::*;
(
    input  logic [FRAC_W-1:0] fx,
    input  logic [FRAC_W-1:0] fy,
    output logic [W_W-1:0]    w00,
    output logic [W_W-1:0]    w01,
    output logic [W_W-1:0]    w10,
    output logic [W_W-1:0]    w11
);

    logic [2*FRAC_W-1:0] prod;
    logic [W_W-1:0]      fx16;
    logic [W_W-1:0]      fy16;

    assign prod = {{FRAC_W{1'b0}}, fx} * {{FRAC_W{1'b0}}, fy};
    assign fx16 = {2'b00, fx};
    assign fy16 = {2'b00, fy};

    // The other three derive from the truncated product so the sum stays exact.
    assign w11 = {2'b00, prod[2*FRAC_W-1:FRAC_W]};
    assign w01 = fx16 - w11;
    assign w10 = fy16 - w11;
    assign w00 = ONE_Q14 - fx16 - fy16 + w11;

endmodule

// File: rtl/bilinear_coef_gen.sv
// Raster walker emitting source 2x2 neighbourhood and bilinear weights per destination pixel.
// Latency: first beat valid two edges after start; then one beat per cycle.
// Backpressure: output register holds while out_valid && !out_ready; the walk stalls.
module bilinear_coef_gen
    import resizer_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    bilinear_coef_gen_if.master bus
);

    state_t           state, state_nxt;
    logic [CW-1:0]    src_w_r, src_h_r, dst_w_r, dst_h_r;
    logic [ACC_W-1:0] step_x_r, step_y_r;
    logic [CW-1:0]    col, row;
    logic [ACC_W-1:0] acc_x, acc_y;
    logic             frame_empty;
    logic             out_valid_q;
    beat_t            beat_q, beat_nxt;
    axis_t            ax, ay;
    logic [W_W-1:0]   w00, w01, w10, w11;
    logic             load_en, col_last, row_last;

    assign load_en  = (state == RUN) && !frame_empty && (!out_valid_q || bus.out_ready);
    assign col_last = (col == dst_w_r - 1'b1);
    assign row_last = (row == dst_h_r - 1'b1);
    assign ax       = clamp_axis(acc_x, src_w_r);
    assign ay       = clamp_axis(acc_y, src_h_r);

    bilinear_weight_calc u_weight_calc (
        .fx  (ax.f),
        .fy  (ay.f),
        .w00 (w00),
        .w01 (w01),
        .w10 (w10),
        .w11 (w11)
    );

    assign beat_nxt = '{x0: ax.i0, y0: ay.i0, x1: ax.i1, y1: ay.i1,
                        w00: w00, w01: w01, w10: w10, w11: w11,
                        last_pix: col_last, last_line: row_last};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // An empty frame spends one cycle in RUN so done lands on the same edge offset as a real frame start.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start) state_nxt = RUN;
            RUN: begin
                if (frame_empty)                        state_nxt = DONE;
                else if (load_en && col_last && row_last) state_nxt = FLUSH;
            end
            FLUSH: if (out_valid_q && bus.out_ready) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_w_r     <= '0;
            src_h_r     <= '0;
            dst_w_r     <= '0;
            dst_h_r     <= '0;
            step_x_r    <= '0;
            step_y_r    <= '0;
            col         <= '0;
            row         <= '0;
            acc_x       <= '0;
            acc_y       <= '0;
            frame_empty <= 1'b0;
            out_valid_q <= 1'b0;
            beat_q      <= '0;
        end else if (state == IDLE && bus.start) begin
            src_w_r     <= bus.src_w;
            src_h_r     <= bus.src_h;
            dst_w_r     <= bus.dst_w;
            dst_h_r     <= bus.dst_h;
            step_x_r    <= bus.step_x;
            step_y_r    <= bus.step_y;
            col         <= '0;
            row         <= '0;
            acc_x       <= '0;
            acc_y       <= '0;
            frame_empty <= (bus.dst_w == '0) || (bus.dst_h == '0);
        end else if (load_en) begin
            beat_q      <= beat_nxt;
            out_valid_q <= 1'b1;
            if (col_last) begin
                col   <= '0;
                acc_x <= '0;
                row   <= row + 1'b1;
                acc_y <= acc_y + step_y_r;
            end else begin
                col   <= col + 1'b1;
                acc_x <= acc_x + step_x_r;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.out_valid = out_valid_q;
    assign bus.x0        = beat_q.x0;
    assign bus.y0        = beat_q.y0;
    assign bus.x1        = beat_q.x1;
    assign bus.y1        = beat_q.y1;
    assign bus.W00       = beat_q.w00;
    assign bus.W01       = beat_q.w01;
    assign bus.W10       = beat_q.w10;
    assign bus.W11       = beat_q.w11;
    assign bus.last_pix  = beat_q.last_pix;
    assign bus.last_line = beat_q.last_line;

endmodule

// File: tb/tb_bilinear_coef_gen.sv
// Directed and randomized frames for bilinear_coef_gen against an index-times-step reference.
// Latency: checks start-to-first-beat, done and busy timing around each frame.
// Backpressure: fixed and random out_ready stalls with field-hold checks.
module tb_bilinear_coef_gen;
    import resizer_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [109:0] beats_q[$];

    bilinear_coef_gen_if bus();

    bilinear_coef_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [109:0] obs_vec();
        return {bus.x0, bus.y0, bus.x1, bus.y1, bus.W00, bus.W01, bus.W10, bus.W11,
                bus.last_pix, bus.last_line};
    endfunction

    // Source position = destination index * step, modulo the 25-bit accumulator.
    function automatic logic [109:0] model(input int sw, input int sh, input int dw, input int dh,
                                           input int stx, input int sty, input int idx);
        int col, row, ix, iy, fx, fy, x0, x1, y0, y1, w00, w01, w10, w11;
        longint ax, ay;
        col = idx % dw;
        row = idx / dw;
        ax  = (longint'(col) * longint'(stx)) % 64'd33554432;
        ay  = (longint'(row) * longint'(sty)) % 64'd33554432;
        ix  = int'(ax / 16384);
        fx  = int'(ax % 16384);
        iy  = int'(ay / 16384);
        fy  = int'(ay % 16384);
        if (ix >= sw - 1) begin x0 = sw - 1; x1 = sw - 1; fx = 0; end
        else begin x0 = ix; x1 = ix + 1; end
        if (iy >= sh - 1) begin y0 = sh - 1; y1 = sh - 1; fy = 0; end
        else begin y0 = iy; y1 = iy + 1; end
        w11 = (fx * fy) / 16384;
        w01 = fx - w11;
        w10 = fy - w11;
        w00 = 16384 - fx - fy + w11;
        return {11'(x0), 11'(y0), 11'(x1), 11'(y1), 16'(w00), 16'(w01), 16'(w10), 16'(w11),
                col == dw - 1, row == dh - 1};
    endfunction

    function automatic bit invariant_ok(input int sw, input int sh);
        int sum;
        sum = int'(bus.W00) + int'(bus.W01) + int'(bus.W10) + int'(bus.W11);
        return (sum == 16384) && (bus.x1 >= bus.x0) && (int'(bus.x1) - int'(bus.x0) <= 1)
            && (bus.y1 >= bus.y0) && (int'(bus.y1) - int'(bus.y0) <= 1)
            && (int'(bus.x1) < sw) && (int'(bus.y1) < sh);
    endfunction

    // mode: 0 always ready, 1 random ready, 2 five-cycle stall at beat 5,
    //       3 reset at beat 10, 4 start pulse at beat 7.
    task automatic run_frame(input string name, input int sw, input int sh, input int dw,
                             input int dh, input int stx, input int sty, input int mode);
        int exp_beats, idx, cyc, budget, stall_left, dones;
        logic held_vld;
        logic [109:0] held, o;
        bit stalled, poked;
        exp_beats = dw * dh;
        budget    = exp_beats * 4 + 50;
        idx = 0; cyc = 0; stall_left = 0; dones = 0;
        held_vld = 1'b0; held = '0; stalled = 1'b0; poked = 1'b0;
        beats_q.delete();

        bus.src_w  = 11'(sw);  bus.src_h  = 11'(sh);
        bus.dst_w  = 11'(dw);  bus.dst_h  = 11'(dh);
        bus.step_x = 25'(stx); bus.step_y = 25'(sty);
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.src_w  = 11'($urandom_range(1, 2047)); bus.src_h = 11'($urandom_range(1, 2047));
        bus.dst_w  = 11'($urandom_range(0, 2047)); bus.dst_h = 11'($urandom_range(0, 2047));
        bus.step_x = 25'($urandom);                bus.step_y = 25'($urandom);
        check({name, "/busy_k"},  128'(bus.busy), 128'(1));
        check({name, "/valid_k"}, 128'(bus.out_valid), 128'(0));
        @(posedge clk); #1;
        check({name, "/valid_k1"}, 128'(bus.out_valid), 128'(1));

        while (idx < exp_beats && cyc < budget) begin
            if (mode == 2 && idx == 5 && !stalled) begin stalled = 1'b1; stall_left = 5; end
            if (stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else if (mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
            else bus.out_ready = 1'b1;
            if (mode == 4) begin
                bus.start = (idx == 7) && !poked;
                if (bus.start) poked = 1'b1;
            end
            if (mode == 3 && idx == 10) begin
                rst_n = 1'b0;
                #1;
                check({name, "/reset_outputs"},
                      128'({bus.busy, bus.done, bus.out_valid, obs_vec()}), 128'(0));
                return;
            end
            o = obs_vec();
            if (bus.done) dones++;
            if (held_vld) check({name, "/hold"}, 128'({bus.out_valid, o}), 128'({1'b1, held}));
            if (bus.out_valid && bus.out_ready) begin
                check({name, "/beat"}, 128'(o), 128'(model(sw, sh, dw, dh, stx, sty, idx)));
                check({name, "/invariant"}, 128'(invariant_ok(sw, sh)), 128'(1));
                beats_q.push_back(o);
                idx++;
                held_vld = 1'b0;
            end else begin
                held_vld = bus.out_valid;
                held     = o;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        check({name, "/beat_count"}, 128'(idx), 128'(exp_beats));
        if (mode == 0) check({name, "/throughput"}, 128'(cyc), 128'(exp_beats));
        check({name, "/done_m"},  128'(bus.done), 128'(1));
        check({name, "/valid_m"}, 128'(bus.out_valid), 128'(0));
        dones += int'(bus.done);
        @(posedge clk); #1;
        dones += int'(bus.done);
        @(posedge clk); #1;
        dones += int'(bus.done);
        check({name, "/busy_m2"},    128'(bus.busy), 128'(0));
        check({name, "/done_count"}, 128'(dones), 128'(1));
    endtask

    initial begin
        bus.start = 1'b0; bus.out_ready = 1'b1;
        bus.src_w = '0; bus.src_h = '0; bus.dst_w = '0; bus.dst_h = '0;
        bus.step_x = '0; bus.step_y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 128'({bus.busy, bus.done, bus.out_valid, obs_vec()}), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 2x upscale with spot values worked out by hand.
        run_frame("up2x", 4, 4, 8, 8, 8192, 8192, 0);
        check("up2x/w_1_0",  128'(beats_q[1][65:2]), 128'({16'd8192, 16'd8192, 16'd0, 16'd0}));
        check("up2x/c_1_1",  128'(beats_q[9][109:66]), 128'({11'd0, 11'd0, 11'd1, 11'd1}));
        check("up2x/w_1_1",  128'(beats_q[9][65:2]), 128'({16'd4096, 16'd4096, 16'd4096, 16'd4096}));
        check("up2x/x_7_0",  128'({beats_q[7][109:99], beats_q[7][87:77]}), 128'({11'd3, 11'd3}));
        check("up2x/w_7_0",  128'(beats_q[7][65:2]), 128'({16'd16384, 16'd0, 16'd0, 16'd0}));

        run_frame("ident3x2", 3, 2, 3, 2, 16384, 16384, 0);
        check("ident3x2/b2_last", 128'(beats_q[2][1:0]), 128'(2'b10));
        check("ident3x2/b5_xy",   128'({beats_q[5][109:99], beats_q[5][98:88]}), 128'({11'd2, 11'd1}));
        check("ident3x2/b5_last", 128'(beats_q[5][1:0]), 128'(2'b11));
        check("ident3x2/b4_w00",  128'(beats_q[4][65:50]), 128'(16'd16384));

        run_frame("stall4x4", 4, 4, 4, 4, 16384, 16384, 2);

        // Empty frame: no beats, done one edge later, then idle.
        bus.src_w = 11'd4; bus.src_h = 11'd4; bus.dst_w = 11'd0; bus.dst_h = 11'd4;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("empty/k", 128'({bus.busy, bus.done, bus.out_valid}), 128'(3'b100));
        @(posedge clk); #1;
        check("empty/k1", 128'({bus.busy, bus.done, bus.out_valid}), 128'(3'b110));
        @(posedge clk); #1;
        check("empty/k2", 128'({bus.busy, bus.done, bus.out_valid}), 128'(3'b000));
        @(posedge clk); #1;

        run_frame("restart_ignored", 4, 4, 4, 4, 16384, 16384, 4);

        run_frame("abort", 4, 4, 8, 8, 8192, 8192, 3);
        @(posedge clk); #1;
        check("abort/held_reset", 128'({bus.busy, bus.out_valid}), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame("after_abort", 4, 4, 8, 8, 8192, 8192, 0);
        check("after_abort/first", 128'(beats_q[0][109:66]), 128'({11'd0, 11'd0, 11'd1, 11'd1}));

        run_frame("sum_inv", 100, 100, 37, 23, 5461, 10923, 1);

        for (int r = 0; r < 3; r++) begin
            run_frame("random", int'($urandom_range(1, 40)), int'($urandom_range(1, 40)),
                      int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
                      int'($urandom_range(0, 40000)), int'($urandom_range(0, 40000)), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
